// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: operation codes,
// default datapath width and the signed-overflow helper.
package pipelined_adder_pkg;

  localparam int XLEN = 32;

  localparam logic ADD_OP = 1'b0;
  localparam logic SUB_OP = 1'b1;

  // Signed overflow occurs when the carry into the MSB differs from the carry out of it.
  function automatic logic calcOverflow(input logic msbCarryIn, input logic msbCarryOut);
    return msbCarryIn ^ msbCarryOut;
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined adder. The master side
// supplies operands and consumes results; the slave side is the adder.
interface pipelined_adder_if
  import pipelined_adder_pkg::*;
#(
  parameter int N = XLEN
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );

endinterface

// File: rtl/pipelined_adder_stage.sv
// One carry-chain segment of the pipelined adder: a SEG-bit ripple adder over
// bits [K*SEG +: SEG] followed by the register slice that carries the partial
// sum, the still-unprocessed operand bits and the segment carries forward.
module pipe_adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int N    = XLEN,
  parameter int SEG  = 8,
  parameter int K    = 0,
  parameter bit LAST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         advance_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] sum_i,
  input  logic         carry_i,
  output logic         valid_o,
  output logic [N-1:0] a_o,
  output logic [N-1:0] b_o,
  output logic [N-1:0] sum_o,
  output logic         carry_o,
  output logic         msbCarry_o,
  output logic [N-1:0] sumNext_o
);

  localparam int LO = K * SEG;

  logic [SEG:0] segSum;
  logic [N-1:0] sum_d;
  logic         carry_d;
  logic         msbCarry_d;

  logic         valid_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [N-1:0] sum_q;
  logic         carry_q;
  logic         msbCarry_q;

  // Add this segment and splice it into the partial sum; the MSB carry-in is recovered from a^b^sum.
  always_comb begin
    segSum     = {1'b0, a_i[LO +: SEG]} + {1'b0, b_i[LO +: SEG]} + {{SEG{1'b0}}, carry_i};
    sum_d      = sum_i;
    sum_d[LO +: SEG] = segSum[SEG-1:0];
    carry_d    = segSum[SEG];
    msbCarry_d = a_i[LO+SEG-1] ^ b_i[LO+SEG-1] ^ segSum[SEG-1];
  end

  // Valid bit follows load/drain with load winning; only the last slice clears its data since it drives the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      if (LAST) begin
        sum_q      <= '0;
        carry_q    <= 1'b0;
        msbCarry_q <= 1'b0;
      end
    end else begin
      if (load_i) begin
        valid_q <= 1'b1;
      end else if (advance_i) begin
        valid_q <= 1'b0;
      end
      if (load_i) begin
        a_q        <= a_i;
        b_q        <= b_i;
        sum_q      <= sum_d;
        carry_q    <= carry_d;
        msbCarry_q <= msbCarry_d;
      end
    end
  end

  assign valid_o    = valid_q;
  assign a_o        = a_q;
  assign b_o        = b_q;
  assign sum_o      = sum_q;
  assign carry_o    = carry_q;
  assign msbCarry_o = msbCarry_q;
  assign sumNext_o  = sum_d;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined N-bit add/subtract unit. The carry chain is cut into STAGES equal
// segments, one per register slice, with a valid/ready handshake on both ends,
// bubble collapsing between slices and full backpressure from the consumer.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int N      = XLEN,
  parameter int STAGES = 4
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_adder_if.slave  bus
);

  localparam int SEG = N / STAGES;

  if ((STAGES < 1) || (STAGES > N) || ((N % STAGES) != 0)) begin : g_paramCheck
    $error("pipelined_adder: N must be a multiple of STAGES with 1 <= STAGES <= N");
  end

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] advance;
  logic              hasRoom;
  logic              inReady;

  logic [N-1:0] aChain     [STAGES+1];
  logic [N-1:0] bChain     [STAGES+1];
  logic [N-1:0] sumChain   [STAGES+1];
  logic         carryChain [STAGES+1];
  logic         msbChain   [STAGES];
  logic [N-1:0] sumNext    [STAGES];

  logic zero_q;

  assign aChain[0]     = bus.a;
  assign bChain[0]     = (bus.sub == SUB_OP) ? ~bus.b : bus.b;
  assign sumChain[0]   = '0;
  assign carryChain[0] = (bus.sub == ADD_OP) ? bus.cin : 1'b1;

  // Walk from the output back to the input: a slice may move if any slice downstream of it has a bubble or the consumer takes the result.
  always_comb begin
    advance = '0;
    load    = '0;
    hasRoom = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      advance[k] = valid[k] && hasRoom;
      hasRoom    = hasRoom || !valid[k];
    end
    inReady = hasRoom;
    load[0] = bus.in_valid && hasRoom;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = advance[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_adder_stage #(
      .N    (N),
      .SEG  (SEG),
      .K    (k),
      .LAST (k == STAGES - 1)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load[k]),
      .advance_i  (advance[k]),
      .a_i        (aChain[k]),
      .b_i        (bChain[k]),
      .sum_i      (sumChain[k]),
      .carry_i    (carryChain[k]),
      .valid_o    (valid[k]),
      .a_o        (aChain[k+1]),
      .b_o        (bChain[k+1]),
      .sum_o      (sumChain[k+1]),
      .carry_o    (carryChain[k+1]),
      .msbCarry_o (msbChain[k]),
      .sumNext_o  (sumNext[k])
    );
  end

  // Zero is evaluated on the complete sum as it enters the last slice so the output flag is a plain register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (load[STAGES-1]) begin
      zero_q <= (sumNext[STAGES-1] == '0);
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = valid[STAGES-1];
  assign bus.sum       = sumChain[STAGES];
  assign bus.cout      = carryChain[STAGES];
  assign bus.overflow  = calcOverflow(msbChain[STAGES-1], carryChain[STAGES]);
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (N=32, STAGES=4): directed vectors,
// streaming, backpressure, mid-flight reset and randomized traffic, all
// scored against a plain-arithmetic reference model.
module tb_pipelined_adder;
  import pipelined_adder_pkg::*;

  localparam int N      = 32;
  localparam int STAGES = 4;
  localparam longint MAXS = (longint'(1) <<< (N - 1)) - 1;
  localparam longint MINS = -(longint'(1) <<< (N - 1));

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } result_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int testsRun    = 0;
  int testsFailed = 0;
  result_t expQ[$];

  pipelined_adder_if #(.N(N)) bus ();

  pipelined_adder #(.N(N), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Reference result from signed/unsigned integer arithmetic.
  function automatic result_t refModel(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic cin, input logic sub);
    result_t r;
    logic [N:0] wide;
    longint sRes;
    if (sub == ADD_OP) begin
      wide   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
      r.sum  = wide[N-1:0];
      r.cout = wide[N];
      sRes   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end else begin
      r.sum  = a - b;
      r.cout = (a >= b);
      sRes   = longint'($signed(a)) - longint'($signed(b));
    end
    r.ovf  = (sRes > MAXS) || (sRes < MINS);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  // Operand generator biased towards carry/overflow corner values.
  function automatic logic [N-1:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(N-1){1'b0}}};
      3:       return {1'b0, {(N-1){1'b1}}};
      default: return $urandom;
    endcase
  endfunction

  // Drive one cycle of inputs just after the falling edge, then sample the handshake and outputs before the rising edge.
  task automatic applyStimulus(input logic v, input logic [N-1:0] ai, input logic [N-1:0] bi,
                               input logic ci, input logic si, input logic rdy,
                               output logic acc, output logic cons, output logic outV,
                               output logic inRdy, output result_t obs);
    @(negedge clk);
    bus.in_valid  = v;
    bus.a         = ai;
    bus.b         = bi;
    bus.cin       = ci;
    bus.sub       = si;
    bus.out_ready = rdy;
    #1;
    inRdy    = bus.in_ready;
    outV     = bus.out_valid;
    acc      = v && bus.in_ready;
    cons     = bus.out_valid && rdy;
    obs.sum  = bus.sum;
    obs.cout = bus.cout;
    obs.ovf  = bus.overflow;
    obs.zero = bus.zero;
    if (acc) expQ.push_back(refModel(ai, bi, ci, si));
  endtask

  task automatic test_reset();
    logic acc, cons, outV, inRdy;
    result_t obs;
    rst_n = 1'b0;
    repeat (2) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, cons, outV, inRdy, obs);
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc, cons, outV, inRdy, obs);
    testsRun++;
    if (outV !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_out_valid: got %b, expected 0", outV);
    end
    testsRun++;
    if (obs !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got sum=%h cout=%b ovf=%b zero=%b, expected all 0",
               obs.sum, obs.cout, obs.ovf, obs.zero);
    end
    testsRun++;
    if (inRdy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_in_ready: got %b, expected 1", inRdy);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] tA [6];
    logic [N-1:0] tB [6];
    logic         tC [6];
    logic         tS [6];
    result_t      tE [6];
    logic acc, cons, outV, inRdy, got;
    result_t obs, gotObs;
    int lat;
    tA = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd7, 32'h8000_0000};
    tB = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'd7, 32'd5, 32'h0000_0001};
    tC = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tS = '{ADD_OP, ADD_OP, ADD_OP, SUB_OP, SUB_OP, SUB_OP};
    tE[0] = {32'h0000_0100, 1'b0, 1'b0, 1'b0};
    tE[1] = {32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tE[2] = {32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tE[3] = {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tE[4] = {32'h0000_0002, 1'b1, 1'b0, 1'b0};
    tE[5] = {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, tA[i], tB[i], tC[i], tS[i], 1'b1, acc, cons, outV, inRdy, obs);
      testsRun++;
      if (acc !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL directed%0d_accept: got %b, expected 1", i, acc);
      end
      got = 1'b0;
      lat = 0;
      gotObs = '0;
      for (int cyc = 1; cyc <= 8 && !got; cyc++) begin
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, cons, outV, inRdy, obs);
        if (cons) begin
          got = 1'b1;
          lat = cyc;
          gotObs = obs;
        end
      end
      testsRun++;
      if (lat != STAGES) begin
        testsFailed++;
        $display("[TB] FAIL directed%0d_latency: got %0d cycles (0 = none within 8), expected %0d",
                 i, lat, STAGES);
      end
      testsRun++;
      if (gotObs !== tE[i]) begin
        testsFailed++;
        $display("[TB] FAIL directed%0d_result: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
                 i, gotObs.sum, gotObs.cout, gotObs.ovf, gotObs.zero,
                 tE[i].sum, tE[i].cout, tE[i].ovf, tE[i].zero);
      end
      expQ.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic acc, cons, outV, inRdy;
    result_t obs, exp;
    int accepts = 0, results = 0, firstCyc = -1, lastCyc = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      applyStimulus(cyc < 10, randOperand(), randOperand(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b1, acc, cons, outV, inRdy, obs);
      if (acc) accepts++;
      if (cons) begin
        if (firstCyc < 0) firstCyc = cyc;
        lastCyc = cyc;
        results++;
        testsRun++;
        if (expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL b2b_spurious: got sum=%h, expected no result", obs.sum);
        end else begin
          exp = expQ.pop_front();
          if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL b2b_result: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
                     obs.sum, obs.cout, obs.ovf, obs.zero, exp.sum, exp.cout, exp.ovf, exp.zero);
          end
        end
      end
    end
    testsRun++;
    if (accepts != 10 || results != 10 || firstCyc != STAGES || lastCyc != STAGES + 9) begin
      testsFailed++;
      $display("[TB] FAIL b2b_stream: got accepts=%0d results=%0d cycles %0d..%0d, expected 10/10 cycles %0d..%0d",
               accepts, results, firstCyc, lastCyc, STAGES, STAGES + 9);
    end
    expQ.delete();
  endtask

  task automatic test_backpressure();
    logic acc, cons, outV, inRdy, fellOk;
    result_t obs, exp, frozen;
    int accepts = 0, extra = 0;
    fellOk = 1'b0;
    frozen = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      applyStimulus(1'b1, randOperand(), randOperand(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0, acc, cons, outV, inRdy, obs);
      if (!inRdy) begin
        fellOk = outV;
        frozen = obs;
        break;
      end
      if (acc) accepts++;
    end
    testsRun++;
    if (accepts != STAGES || !fellOk) begin
      testsFailed++;
      $display("[TB] FAIL bp_fill: got %0d accepts before in_ready fell (out_valid=%b), expected %0d with out_valid=1",
               accepts, fellOk, STAGES);
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      applyStimulus(1'b1, randOperand(), randOperand(), 1'b0, 1'b0, 1'b0, acc, cons, outV, inRdy, obs);
      testsRun++;
      if (obs !== frozen || outV !== 1'b1 || inRdy !== 1'b0 || acc !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL bp_hold: got sum=%h valid=%b in_ready=%b, expected sum=%h valid=1 in_ready=0",
                 obs.sum, outV, inRdy, frozen.sum);
      end
    end
    for (int cyc = 0; cyc < 20 && expQ.size() != 0; cyc++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, cons, outV, inRdy, obs);
      if (cons) begin
        exp = expQ.pop_front();
        testsRun++;
        if (obs !== exp) begin
          testsFailed++;
          $display("[TB] FAIL bp_drain: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
                   obs.sum, obs.cout, obs.ovf, obs.zero, exp.sum, exp.cout, exp.ovf, exp.zero);
        end
      end
    end
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL bp_lost: got %0d results still missing, expected 0", expQ.size());
    end
    repeat (3) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, cons, outV, inRdy, obs);
      if (cons) extra++;
    end
    testsRun++;
    if (extra != 0) begin
      testsFailed++;
      $display("[TB] FAIL bp_duplicate: got %0d extra results, expected 0", extra);
    end
    expQ.delete();
  endtask

  task automatic test_reset_midflight();
    logic acc, cons, outV, inRdy;
    result_t obs, exp;
    int stale = 0, seen = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, randOperand(), randOperand(), 1'b0, 1'($urandom_range(0, 1)), 1'b1,
                    acc, cons, outV, inRdy, obs);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, cons, outV, inRdy, obs);
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, cons, outV, inRdy, obs);
    rst_n = 1'b1;
    expQ.delete();
    testsRun++;
    if (outV !== 1'b0 || obs !== '0 || inRdy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midreset_state: got valid=%b sum=%h cout=%b ovf=%b zero=%b in_ready=%b, expected 0/0/0/0/0/1",
               outV, obs.sum, obs.cout, obs.ovf, obs.zero, inRdy);
    end
    repeat (10) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, cons, outV, inRdy, obs);
      if (outV) stale++;
    end
    testsRun++;
    if (stale != 0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_stale: got %0d stale results, expected 0", stale);
    end
    applyStimulus(1'b1, 32'h1234_5678, 32'h0000_1111, 1'b1, ADD_OP, 1'b1, acc, cons, outV, inRdy, obs);
    for (int cyc = 0; cyc < 8; cyc++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, cons, outV, inRdy, obs);
      if (cons && expQ.size() != 0) begin
        exp = expQ.pop_front();
        seen++;
        testsRun++;
        if (obs !== exp) begin
          testsFailed++;
          $display("[TB] FAIL midreset_after: got sum=%h, expected sum=%h", obs.sum, exp.sum);
        end
      end
    end
    testsRun++;
    if (seen != 1) begin
      testsFailed++;
      $display("[TB] FAIL midreset_resume: got %0d results, expected 1", seen);
    end
    expQ.delete();
  endtask

  task automatic test_random();
    logic acc, cons, outV, inRdy;
    result_t obs, exp;
    int accepts = 0, results = 0;
    for (int cyc = 0; cyc < 3000 + 60; cyc++) begin
      logic v, r;
      v = (cyc < 3000) && ($urandom_range(0, 3) != 0);
      r = (cyc >= 3000) || ($urandom_range(0, 9) < 7);
      applyStimulus(v, randOperand(), randOperand(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), r, acc, cons, outV, inRdy, obs);
      if (acc) accepts++;
      if (cons) begin
        results++;
        testsRun++;
        if (expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL random_spurious: got sum=%h, expected no result", obs.sum);
        end else begin
          exp = expQ.pop_front();
          if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL random_result: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
                     obs.sum, obs.cout, obs.ovf, obs.zero, exp.sum, exp.cout, exp.ovf, exp.zero);
          end
        end
      end
    end
    testsRun++;
    if (results != accepts || expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL random_count: got %0d results for %0d accepts, expected equal", results, accepts);
    end
    expQ.delete();
  endtask

  // Hard stop in case the design wedges the handshake.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Run every scenario in order and report.
  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
